// File: rtl/ex_pkg.sv
// Shared encodings for the execute/writeback stage: ALU opcodes, FSM states
// and multiplier iteration count.
package ex_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SLL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = $clog2(MUL_ITERS);

endpackage

// File: rtl/ex_wb_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per enabled cycle,
// low WIDTH bits only.
module mul_iter
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] prod_o
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= '0;
        end else if (en_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // prod_o already includes the partial product of the iteration in flight,
    // so on the last edge it is the finished result.
    assign last_o = en_i && (cnt_q == CNT_W'(MUL_ITERS - 1));
    assign prod_o = acc_d;

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage feeding the register-file write port.
// Optional macro EX_BYPASS_EN forwards the in-flight write to operands A/B.
module ex_wb_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    rn1,
    input  logic [AW-1:0]    rn2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] imm,
    input  logic             use_imm,
    input  logic [AW-1:0]    wn_in,
    input  logic             we_in,
    output logic [WIDTH-1:0] wd,
    output logic [AW-1:0]    wn,
    output logic             w,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q;
    logic             w_q;
    logic [WIDTH-1:0] wd_q;
    logic [AW-1:0]    wn_q;
    logic             mulWe_q;
    logic [AW-1:0]    mulWn_q;

    logic             accept;
    logic             mulStart;
    logic             mulLast;
    logic [WIDTH-1:0] mulProd;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] aluRes;

    assign accept   = valid_in && (state_q == ST_IDLE);
    assign mulStart = accept && (op_e'(op) == OP_MUL);

`ifdef EX_BYPASS_EN
    // The rf write landing on this edge is not yet visible on rd1/rd2.
    logic fwdA;
    logic fwdB;
    assign fwdA = w_q && (wn_q != '0) && (rn1 == wn_q);
    assign fwdB = w_q && (wn_q != '0) && (rn2 == wn_q);
    assign opA  = fwdA ? wd_q : rd1;
    assign opB  = use_imm ? imm : (fwdB ? wd_q : rd2);
`else
    logic unusedRn;
    assign unusedRn = ^{rn1, rn2};
    assign opA      = rd1;
    assign opB      = use_imm ? imm : rd2;
`endif

    always_comb begin
        aluRes = '0;
        case (op_e'(op))
            OP_ADD:  aluRes = opA + opB;
            OP_SUB:  aluRes = opA - opB;
            OP_AND:  aluRes = opA & opB;
            OP_OR:   aluRes = opA | opB;
            OP_NOR:  aluRes = ~(opA | opB);
            OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            OP_SLL:  aluRes = opA << opB[SHW-1:0];
            default: aluRes = '0;
        endcase
    end

    mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(mulStart),
        .en_i   (state_q == ST_MUL),
        .a_i    (opA),
        .b_i    (opB),
        .last_o (mulLast),
        .prod_o (mulProd)
    );

    // wd/wn only move when a write is issued, so they hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w_q     <= 1'b0;
            wd_q    <= '0;
            wn_q    <= '0;
            mulWe_q <= 1'b0;
            mulWn_q <= '0;
        end else begin
            w_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_e'(op) == OP_MUL) begin
                            state_q <= ST_MUL;
                            mulWe_q <= we_in && (wn_in != '0);
                            mulWn_q <= wn_in;
                        end else if (we_in && (wn_in != '0)) begin
                            w_q  <= 1'b1;
                            wd_q <= aluRes;
                            wn_q <= wn_in;
                        end
                    end
                end
                ST_MUL: begin
                    if (mulLast) begin
                        state_q <= ST_IDLE;
                        if (mulWe_q) begin
                            w_q  <= 1'b1;
                            wd_q <= mulProd;
                            wn_q <= mulWn_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w        = w_q;
    assign wd       = wd_q;
    assign wn       = wn_q;
    assign busy     = (state_q == ST_MUL);
    assign ready_in = (state_q == ST_IDLE);

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: vector table plus write scoreboard.
module tb_ex_wb_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [2:0]  op;
    logic [4:0]  rn1, rn2;
    logic [31:0] rd1, rd2, imm;
    logic        use_imm;
    logic [4:0]  wn_in;
    logic        we_in;
    logic [31:0] wd;
    logic [4:0]  wn;
    logic        w;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  wn;
        logic [31:0] wd;
    } wr_t;
    wr_t sbq[$];

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        useImm;
        logic [4:0]  wn;
        logic        we;
        logic        expW;
        logic [31:0] expWd;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    ex_wb_stage #(.WIDTH(32), .AW(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .op      (op),
        .rn1     (rn1),
        .rn2     (rn2),
        .rd1     (rd1),
        .rd2     (rd2),
        .imm     (imm),
        .use_imm (use_imm),
        .wn_in   (wn_in),
        .we_in   (we_in),
        .wd      (wd),
        .wn      (wn),
        .w       (w),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic setInstr(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic ui, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [4:0] dst, input logic we);
        valid_in = 1'b1;
        op       = o;
        rd1      = a;
        rd2      = b;
        imm      = im;
        use_imm  = ui;
        rn1      = r1;
        rn2      = r2;
        wn_in    = dst;
        we_in    = we;
    endtask

    task automatic waitReady(input string name);
        int guard = 0;
        while (!ready_in && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_in) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_ready_timeout: got ready_in=0 want 1", name);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        setInstr(v.op, v.a, v.b, v.imm, v.useImm, 5'd0, 5'd0, v.wn, v.we);
        waitReady(v.name);
        if (v.expW) sbq.push_back('{wn: v.wn, wd: v.expWd});
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v);
        int stall = 0;
        if (v.op == OP_MUL) begin
            while (!ready_in && stall < 100) begin
                @(negedge clk);
                stall++;
            end
            check({v.name, "_stall"}, 32'(stall), 32'd32);
        end
        check({v.name, "_w"}, {31'd0, w}, {31'd0, v.expW});
        @(negedge clk);
        check({v.name, "_wnext"}, {31'd0, w}, 32'd0);
    endtask

    // Every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && w === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("[TB] FAIL spurious_write: got wn=%0d wd=0x%08h want no write", wn, wd);
            end else begin
                e = sbq.pop_front();
                if (e.wn !== wn || e.wd !== wd) begin
                    bad++;
                    $display("[TB] FAIL wb_data: got wn=%0d wd=0x%08h want wn=%0d wd=0x%08h",
                             wn, wd, e.wn, e.wd);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] expBypass;

        vecs[0]  = '{"add",     OP_ADD, 32'd5,        32'd7,        32'd0,  1'b0, 5'd3,  1'b1, 1'b1, 32'd12};
        vecs[1]  = '{"sub",     OP_SUB, 32'd5,        32'd7,        32'd0,  1'b0, 5'd4,  1'b1, 1'b1, 32'hFFFF_FFFE};
        vecs[2]  = '{"and",     OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,  1'b0, 5'd5,  1'b1, 1'b1, 32'hF000_F000};
        vecs[3]  = '{"or",      OP_OR,  32'hF0F0F0F0, 32'h0F0F0000, 32'd0,  1'b0, 5'd6,  1'b1, 1'b1, 32'hFFFF_F0F0};
        vecs[4]  = '{"nor",     OP_NOR, 32'h0000FFFF, 32'h00FF0000, 32'd0,  1'b0, 5'd7,  1'b1, 1'b1, 32'hFF00_0000};
        vecs[5]  = '{"slt_neg", OP_SLT, 32'hFFFFFFFF, 32'd1,        32'd0,  1'b0, 5'd8,  1'b1, 1'b1, 32'd1};
        vecs[6]  = '{"slt_pos", OP_SLT, 32'd1,        32'hFFFFFFFF, 32'd0,  1'b0, 5'd9,  1'b1, 1'b1, 32'd0};
        vecs[7]  = '{"sll_imm", OP_SLL, 32'd1,        32'd0,        32'd31, 1'b1, 5'd10, 1'b1, 1'b1, 32'h8000_0000};
        vecs[8]  = '{"sll_lo5", OP_SLL, 32'd3,        32'h24,       32'd0,  1'b0, 5'd11, 1'b1, 1'b1, 32'h30};
        vecs[9]  = '{"add_imm", OP_ADD, 32'hFFFFFFFF, 32'd100,      32'd1,  1'b1, 5'd12, 1'b1, 1'b1, 32'd0};
        vecs[10] = '{"wr_r0",   OP_ADD, 32'd5,        32'd7,        32'd0,  1'b0, 5'd0,  1'b1, 1'b0, 32'd0};
        vecs[11] = '{"we_off",  OP_ADD, 32'd5,        32'd7,        32'd0,  1'b0, 5'd13, 1'b0, 1'b0, 32'd0};
        vecs[12] = '{"mul",     OP_MUL, 32'd12345,    32'd6789,     32'd0,  1'b0, 5'd14, 1'b1, 1'b1, 32'd83810205};
        vecs[13] = '{"mul_neg", OP_MUL, 32'hFFFFFFFF, 32'd3,        32'd0,  1'b0, 5'd15, 1'b1, 1'b1, 32'hFFFF_FFFD};

        rst_n = 1'b0;
        setInstr(OP_ADD, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_w",     {31'd0, w},        32'd0);
        check("rst_wd",    wd,                32'd0);
        check("rst_wn",    {27'd0, wn},       32'd0);
        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_ready", {31'd0, ready_in}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Back-to-back ALU accepts give back-to-back writes.
        @(negedge clk);
        check("b2b_ready", {31'd0, ready_in}, 32'd1);
        setInstr(OP_ADD, 32'd10, 32'd20, '0, 1'b0, '0, '0, 5'd1, 1'b1);
        sbq.push_back('{wn: 5'd1, wd: 32'd30});
        @(negedge clk);
        setInstr(OP_SUB, 32'd10, 32'd20, '0, 1'b0, '0, '0, 5'd2, 1'b1);
        sbq.push_back('{wn: 5'd2, wd: 32'hFFFF_FFF6});
        check("b2b_w1", {31'd0, w}, 32'd1);
        @(negedge clk);
        valid_in = 1'b0;
        check("b2b_w2", {31'd0, w}, 32'd1);
        @(negedge clk);
        check("b2b_w3", {31'd0, w}, 32'd0);

        // An instruction held during a MUL is taken only once ready_in returns.
        begin
            int n = 0;
            setInstr(OP_MUL, 32'd12345, 32'd6789, '0, 1'b0, '0, '0, 5'd20, 1'b1);
            sbq.push_back('{wn: 5'd20, wd: 32'd83810205});
            @(negedge clk);
            setInstr(OP_ADD, 32'd1, 32'd2, '0, 1'b0, '0, '0, 5'd21, 1'b1);
            check("hold_busy", {31'd0, busy}, 32'd1);
            while (!ready_in && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("hold_stall", 32'(n), 32'd32);
            check("hold_mul_w", {31'd0, w}, 32'd1);
            sbq.push_back('{wn: 5'd21, wd: 32'd3});
            @(negedge clk);
            valid_in = 1'b0;
            check("hold_add_w", {31'd0, w}, 32'd1);
            check("hold_idle", {31'd0, busy}, 32'd0);
        end

        // Reset in the middle of a MUL aborts it without a write.
        @(negedge clk);
        setInstr(OP_MUL, 32'd7, 32'd9, '0, 1'b0, '0, '0, 5'd22, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_w",     {31'd0, w},        32'd0);
        check("abort_ready", {31'd0, ready_in}, 32'd1);
        check("abort_busy",  {31'd0, busy},     32'd0);
        check("abort_wd",    wd,                32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_ready2", {31'd0, ready_in}, 32'd1);

        // Dependent instruction right behind a write, on rn1 then on rn2.
`ifdef EX_BYPASS_EN
        expBypass = 32'd13;
`else
        expBypass = 32'd1;
`endif
        @(negedge clk);
        setInstr(OP_ADD, 32'd5, 32'd7, '0, 1'b0, '0, '0, 5'd3, 1'b1);
        sbq.push_back('{wn: 5'd3, wd: 32'd12});
        @(negedge clk);
        setInstr(OP_ADD, 32'd0, 32'd1, '0, 1'b0, 5'd3, 5'd0, 5'd4, 1'b1);
        sbq.push_back('{wn: 5'd4, wd: expBypass});
        @(negedge clk);
        valid_in = 1'b0;
        check("byp_a_w", {31'd0, w}, 32'd1);
        check("byp_a_wd", wd, expBypass);

`ifdef EX_BYPASS_EN
        expBypass = 32'd14;
`else
        expBypass = 32'd2;
`endif
        @(negedge clk);
        setInstr(OP_ADD, 32'd5, 32'd7, '0, 1'b0, '0, '0, 5'd3, 1'b1);
        sbq.push_back('{wn: 5'd3, wd: 32'd12});
        @(negedge clk);
        setInstr(OP_ADD, 32'd2, 32'd0, '0, 1'b0, 5'd0, 5'd3, 5'd5, 1'b1);
        sbq.push_back('{wn: 5'd5, wd: expBypass});
        @(negedge clk);
        valid_in = 1'b0;
        check("byp_b_wd", wd, expBypass);
        repeat (3) @(negedge clk);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
